lbp_engine_param: RTL
=====================

Name: lbp_engine_param

Overview:
Parametrised successor to the fixed 128x128 LBP engine. It reads a grayscale image from external memory in raster order through a req/addr/data read port, computes the 8-bit Local Binary Pattern of every pixel, and writes one result per pixel through a valid/addr/data write port. New over the previous generation:
- Image size and pixel width are generic.
- Comparison mode is selectable at runtime (>= or strict >).
- Border policy is selectable at runtime (write zero, or skip).
- A column-sliding window cuts steady-state fetches from 9 to 3 per pixel.

Parameters:
LOG_W, 7, log2 of image width W (W = 2**LOG_W, W >= 4)
LOG_H, 7, log2 of image height H (H = 2**LOG_H, H >= 4)
PIX_W, 8, gray pixel width in bits

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cmp_strict  in  1  0: bit = (neighbour >= centre); 1: bit = (neighbour > centre); sampled at start
border_skip  in  1  0: border pixels written as 0; 1: border pixels produce no write; sampled at start
gray_ready  in  1  memory ready; a frame starts on the first cycle it is seen high in IDLE
gray_addr  out  LOG_H+LOG_W  read address {row,col}
gray_req  out  1  read request
gray_data  in  PIX_W  read data; valid the cycle after gray_addr/gray_req=1
lbp_addr  out  LOG_H+LOG_W  write address {row,col}
lbp_valid  out  1  one-cycle write strobe
lbp_data  out  8  LBP result
finish  out  1  frame complete; held high until reset

Behaviour:
- One clock. Reset is synchronous and active-high. All state is cleared on a reset edge, including mid-frame; no partial writes follow reset.
- Reset values: gray_addr=0, gray_req=0, lbp_addr=0, lbp_valid=0, lbp_data=0, finish=0, FSM=IDLE.
- Traversal: raster order, row-major, (0,0) to (H-1,W-1). Border pixel = row 0, row H-1, col 0 or col W-1.
- States:
  - IDLE: wait for gray_ready=1; latch cmp_strict and border_skip; go to BORDER at (0,0).
  - BORDER: 1 cycle per border pixel. With border_skip=0, drive lbp_valid=1, lbp_data=0, lbp_addr={row,col}; with border_skip=1, lbp_valid=0. Advance position. Next pixel interior: FETCH9 if col==1, else SLIDE3. Last pixel (H-1,W-1) done: DONE.
  - FETCH9: issue 9 reads on consecutive cycles, column-major: (r-1,c-1),(r,c-1),(r+1,c-1),(r-1,c),(r,c),(r+1,c),(r-1,c+1),(r,c+1),(r+1,c+1). gray_req=1 on each. Data is captured one cycle later, so there is 1 tail cycle. Then go to WRITE.
  - SLIDE3: window shifts left one column in the first cycle. Issue 3 reads for column c+1 (rows r-1,r,r+1), plus 1 tail cycle, then WRITE.
  - WRITE: lbp_valid=1 for 1 cycle, lbp_addr={r,c}, lbp_data computed from the window. gray_req=0. Advance position: col==W-2 goes to BORDER, else SLIDE3.
  - DONE: finish=1, all strobes 0. Held until reset; gray_ready is ignored.
- gray_req=0 in every state except FETCH9/SLIDE3 issue cycles.
- LBP bit order (centre C): b0=TL, b1=T, b2=TR, b3=L, b4=R, b5=BL, b6=B, b7=BR. Comparisons are unsigned, PIX_W bits.
- Timing: interior pixel period is 5 cycles in SLIDE3 and 11 cycles for the first interior pixel of a row.
- Address arithmetic is LOG_W/LOG_H wide. Neighbour addresses are formed only for interior pixels, so no wrap occurs.
- lbp_valid never asserts twice for the same address. The frame produces W*H writes (border_skip=0) or (W-2)*(H-2) writes (border_skip=1).

Decomposition:
- Shared package lbp_pkg:
  - FSM state enum (IDLE, BORDER, FETCH9, SLIDE3, WRITE, DONE).
  - Neighbour bit-index constants.
  - Address pack helper.
- Sub-module lbp_window3x3: 3x3 register window with load-by-index, shift-left and compare logic. Inputs: data, index, shift, strict. Output: 8-bit code.

Test Plan:
- LOG_W=LOG_H=3, all pixels 0x55, cmp_strict=0, border_skip=0: 64 writes; interior codes 0xFF, border codes 0x00; then finish=1.
- Same image, cmp_strict=1: every interior code is 0x00.
- Pixel = col (horizontal ramp), cmp_strict=0: interior code 0xD6. With cmp_strict=1: interior code 0x94.
- border_skip=1, 8x8: exactly 36 writes, addresses {1..6,1..6} in raster order, no duplicates. finish rises 1 cycle after the (7,7) BORDER cycle.
- Read timing: check gray_req high only on issue cycles; 9 reads for col 1, 3 reads for each later interior col. Period between interior lbp_valid pulses is 5 cycles.
- Assert reset mid-row (row 3, SLIDE3): next cycle all outputs are 0. After gray_ready, the frame restarts at (0,0) and completes correctly.

Source files
------------

// File: rtl/lbp_pkg.sv
// Shared types and helpers for the parametrised LBP engine: FSM states, neighbour
// positions inside the 3x3 window and {row,col} address packing.
package lbp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StBorder,
    StFetch9,
    StSlide3,
    StWrite,
    StDone
  } state_e;

  // Window slot = col*3 + row, which matches the column-major fetch order.
  localparam int unsigned NbTl   = 0;
  localparam int unsigned NbT    = 3;
  localparam int unsigned NbTr   = 6;
  localparam int unsigned NbL    = 1;
  localparam int unsigned NbR    = 7;
  localparam int unsigned NbBl   = 2;
  localparam int unsigned NbB    = 5;
  localparam int unsigned NbBr   = 8;
  localparam int unsigned Centre = 4;

  function automatic int unsigned nb_index(input int unsigned bit_pos);
    case (bit_pos)
      0:       return NbTl;
      1:       return NbT;
      2:       return NbTr;
      3:       return NbL;
      4:       return NbR;
      5:       return NbBl;
      6:       return NbB;
      default: return NbBr;
    endcase
  endfunction

  function automatic logic [31:0] pack_addr(input logic [15:0] row, input logic [15:0] col,
                                            input int unsigned log_w);
    return (32'(row) << log_w) | 32'(col);
  endfunction

endpackage

// File: rtl/lbp_window3x3.sv
// 3x3 pixel window: indexed load, left shift by one column and the 8-bit LBP compare.
module lbp_window3x3
  import lbp_pkg::*;
#(
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [3:0]       index,
  input  logic [PIX_W-1:0] data,
  input  logic             shift,
  input  logic             strict,
  output logic [7:0]       code
);

  logic [PIX_W-1:0] win_q [9];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      if (shift) begin
        for (int i = 0; i < 6; i++) win_q[i] <= win_q[i+3];
      end
      if (load) begin
        for (int i = 0; i < 9; i++) begin
          if (index == 4'(i)) win_q[i] <= data;
        end
      end
    end
  end

  always_comb begin
    code = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (strict) code[b] = win_q[nb_index(b)] > win_q[Centre];
      else        code[b] = win_q[nb_index(b)] >= win_q[Centre];
    end
  end

endmodule

// File: rtl/lbp_engine_param.sv
// Raster-order LBP engine with generic image size, runtime compare mode and border policy.
// Interior pixels reuse the previous window and fetch only the new right-hand column.
module lbp_engine_param
  import lbp_pkg::*;
#(
  parameter int unsigned LOG_W = 7,
  parameter int unsigned LOG_H = 7,
  parameter int unsigned PIX_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmp_strict,
  input  logic                   border_skip,
  input  logic                   gray_ready,
  output logic [LOG_H+LOG_W-1:0] gray_addr,
  output logic                   gray_req,
  input  logic [PIX_W-1:0]       gray_data,
  output logic [LOG_H+LOG_W-1:0] lbp_addr,
  output logic                   lbp_valid,
  output logic [7:0]             lbp_data,
  output logic                   finish
);

  localparam int unsigned AW = LOG_H + LOG_W;
  localparam logic [LOG_W-1:0] ColMax = '1;
  localparam logic [LOG_W-1:0] ColPen = ColMax - LOG_W'(1);
  localparam logic [LOG_H-1:0] RowMax = '1;

  state_e           state_q, state_d;
  logic [LOG_H-1:0] row_q, row_d;
  logic [LOG_W-1:0] col_q, col_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             strict_q, strict_d;
  logic             skip_q, skip_d;

  logic             win_load, win_shift;
  logic [3:0]       win_idx;
  logic [7:0]       code;

  logic [LOG_H-1:0] nxt_row, rd_row;
  logic [LOG_W-1:0] nxt_col, rd_col;
  logic             nxt_interior;
  logic [AW-1:0]    pix_addr, rd_addr;

  lbp_window3x3 #(
    .PIX_W(PIX_W)
  ) u_window (
    .clk   (clk),
    .reset (reset),
    .load  (win_load),
    .index (win_idx),
    .data  (gray_data),
    .shift (win_shift),
    .strict(strict_q),
    .code  (code)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      row_q    <= '0;
      col_q    <= '0;
      cnt_q    <= '0;
      strict_q <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      strict_q <= strict_d;
      skip_q   <= skip_d;
    end
  end

  // Raster successor of the current position and the address of the current read.
  always_comb begin
    if (col_q == ColMax) begin
      nxt_row = row_q + LOG_H'(1);
      nxt_col = '0;
    end else begin
      nxt_row = row_q;
      nxt_col = col_q + LOG_W'(1);
    end
    nxt_interior = (nxt_row != '0) && (nxt_row != RowMax) &&
                   (nxt_col != '0) && (nxt_col != ColMax);
    if (state_q == StFetch9) begin
      rd_row = row_q + LOG_H'(cnt_q % 4'd3) - LOG_H'(1);
      rd_col = col_q + LOG_W'(cnt_q / 4'd3) - LOG_W'(1);
    end else begin
      rd_row = row_q + LOG_H'(cnt_q) - LOG_H'(1);
      rd_col = col_q + LOG_W'(1);
    end
    pix_addr = AW'(pack_addr(16'(row_q), 16'(col_q), LOG_W));
    rd_addr  = AW'(pack_addr(16'(rd_row), 16'(rd_col), LOG_W));
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    strict_d  = strict_q;
    skip_d    = skip_q;
    gray_req  = 1'b0;
    gray_addr = '0;
    lbp_valid = 1'b0;
    lbp_addr  = '0;
    lbp_data  = '0;
    finish    = 1'b0;
    win_load  = 1'b0;
    win_shift = 1'b0;
    win_idx   = '0;

    unique case (state_q)
      StIdle: begin
        if (gray_ready) begin
          strict_d = cmp_strict;
          skip_d   = border_skip;
          row_d    = '0;
          col_d    = '0;
          cnt_d    = '0;
          state_d  = StBorder;
        end
      end
      StBorder: begin
        lbp_valid = !skip_q;
        lbp_addr  = skip_q ? '0 : pix_addr;
        if (row_q == RowMax && col_q == ColMax) begin
          state_d = StDone;
        end else begin
          row_d = nxt_row;
          col_d = nxt_col;
          cnt_d = '0;
          if (nxt_interior) state_d = (nxt_col == LOG_W'(1)) ? StFetch9 : StSlide3;
        end
      end
      StFetch9: begin
        // Read data lands one cycle after its request, so slot k fills on count k+1.
        gray_req  = cnt_q < 4'd9;
        gray_addr = gray_req ? rd_addr : '0;
        win_load  = cnt_q != 4'd0;
        win_idx   = cnt_q - 4'd1;
        if (cnt_q == 4'd9) begin
          cnt_d   = '0;
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StSlide3: begin
        gray_req  = cnt_q < 4'd3;
        gray_addr = gray_req ? rd_addr : '0;
        win_shift = cnt_q == 4'd0;
        win_load  = cnt_q != 4'd0;
        win_idx   = cnt_q + 4'd5;
        if (cnt_q == 4'd3) begin
          cnt_d   = '0;
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWrite: begin
        lbp_valid = 1'b1;
        lbp_addr  = pix_addr;
        lbp_data  = code;
        cnt_d     = '0;
        col_d     = col_q + LOG_W'(1);
        state_d   = (col_q == ColPen) ? StBorder : StSlide3;
      end
      StDone: begin
        finish = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
